// File: rtl/recursion_controller_if.sv
// ---------------------------------------------------------------------------
// recursion_controller_if
//   Bundles the host handshake, the datapath strobes and the datapath status
//   lines of the recursion controller.
//   master : the controller side (drives ready/busy/finish/err/steps/strobes)
//   slave  : the host + datapath side (drives start and the status lines)
// Signals
//   start                       host request
//   ready, busy, finish, err    host status
//   steps[STEP_W]               CHECK visits in current/last run
//   load_init, updater, alu, res_updater, cal_res, poping, dont_check
//                               datapath strobes
//   updated, done, backtrack, cal_update
//                               datapath status
// ---------------------------------------------------------------------------
interface recursion_controller_if #(
  parameter int STEP_W = 10
);
  logic              start;
  logic              ready;
  logic              busy;
  logic              finish;
  logic              err;
  logic [STEP_W-1:0] steps;
  logic              load_init;
  logic              updater;
  logic              alu;
  logic              res_updater;
  logic              cal_res;
  logic              poping;
  logic              dont_check;
  logic              updated;
  logic              done;
  logic              backtrack;
  logic              cal_update;

  modport master (
    input  start, updated, done, backtrack, cal_update,
    output ready, busy, finish, err, steps,
           load_init, updater, alu, res_updater, cal_res, poping, dont_check
  );

  modport slave (
    output start, updated, done, backtrack, cal_update,
    input  ready, busy, finish, err, steps,
           load_init, updater, alu, res_updater, cal_res, poping, dont_check
  );
endinterface

// File: rtl/recursion_controller.sv
// ---------------------------------------------------------------------------
// recursion_controller
//   Command-issuing FSM for the memoised-recursion datapath computing
//   value[n] = 2*value[n-1] + 3*value[n-2], value[0] = value[1] = 1.
//   Sequences the datapath strobes, watches the status lines, reports
//   completion to the host and aborts runaway runs with a CHECK-visit watchdog.
// Parameters
//   MAX_STEPS  CHECK visits allowed per run before err is raised
//   STEP_W     width of the step counter (2**STEP_W > MAX_STEPS)
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-low reset (0 = reset)
//   bus   recursion_controller_if.master (host handshake, strobes, status)
// ---------------------------------------------------------------------------
module recursion_controller #(
  parameter int MAX_STEPS = 1023,
  parameter int STEP_W    = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  recursion_controller_if.master         bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_UPD,
    S_WUPD,
    S_EVAL,
    S_DESC,
    S_CALC,
    S_WCAL,
    S_POP,
    S_FIN,
    S_FAIL
  } state_t;

  // Old step value at which the CHECK visit being made is the last allowed one.
  localparam logic [STEP_W-1:0] LIMIT = STEP_W'(MAX_STEPS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [STEP_W-1:0] r_steps;
  logic              w_accept;

  // A start is honoured only from IDLE or FAIL; anywhere else it is dropped.
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_FAIL));

  // State register and step counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_steps <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_steps <= '0;
      end else if ((r_state == S_CHECK) && (r_steps != '1)) begin
        // Saturating so a host readout never sees a wrapped count.
        r_steps <= r_steps + STEP_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_CHECK;
      S_CHECK: begin
        // done outranks the watchdog on the final allowed visit.
        if (bus.done)              w_state_next = S_FIN;
        else if (r_steps == LIMIT) w_state_next = S_FAIL;
        else                       w_state_next = S_UPD;
      end
      S_UPD:   w_state_next = S_WUPD;
      S_WUPD:  if (bus.updated) w_state_next = S_EVAL;
      S_EVAL:  w_state_next = bus.backtrack ? S_CALC : S_DESC;
      S_DESC:  w_state_next = S_CHECK;
      S_CALC:  w_state_next = S_WCAL;
      S_WCAL:  if (bus.cal_update) w_state_next = S_POP;
      S_POP:   w_state_next = S_CHECK;
      S_FIN:   w_state_next = S_IDLE;
      S_FAIL:  if (bus.start) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    bus.ready       = (r_state == S_IDLE);
    bus.busy        = (r_state != S_IDLE) && (r_state != S_FAIL);
    bus.finish      = (r_state == S_FIN);
    // FAIL is left only through an accepted start, so err clears exactly then.
    bus.err         = (r_state == S_FAIL);
    bus.steps       = r_steps;
    bus.load_init   = (r_state == S_LOAD);
    bus.updater     = (r_state == S_UPD);
    bus.alu         = (r_state == S_EVAL);
    bus.res_updater = (r_state == S_DESC);
    bus.cal_res     = (r_state == S_CALC);
    bus.poping      = (r_state == S_POP);
    // Mask the datapath done check until the stack size has been loaded.
    bus.dont_check  = (r_state == S_IDLE) || (r_state == S_LOAD) ||
                      (r_state == S_FIN)  || (r_state == S_FAIL);
  end

endmodule
